// File: rtl/odd_issue_scoreboard_pkg.sv
// Shared definitions for the odd-pipe issue stage: unit codes, packed-stage layout,
// held-instruction record and the scoreboard initial-count helper.
package odd_issue_scoreboard_pkg;

  localparam int unsigned SB_NREG    = 128;
  localparam int unsigned SB_CNT_W   = 4;
  localparam int unsigned SB_STALL_W = 16;
  localparam int unsigned REG_AW     = 7;

  localparam logic [2:0] UNIT_NOP  = 3'b000;
  localparam logic [2:0] UNIT_PERM = 3'b100;
  localparam logic [2:0] UNIT_LS   = 3'b101;
  localparam logic [2:0] UNIT_BR   = 3'b110;

  localparam logic [6:0] NOP_INSTR_ID = 7'd0;

  // Bit offsets inside a packed forwarding stage.
  localparam int unsigned PK_UNIT_LSB    = 0;
  localparam int unsigned PK_UNIT_MSB    = 2;
  localparam int unsigned PK_RESULT_LSB  = 3;
  localparam int unsigned PK_RESULT_MSB  = 130;
  localparam int unsigned PK_REGDST_LSB  = 131;
  localparam int unsigned PK_REGDST_MSB  = 137;
  localparam int unsigned PK_LATENCY_LSB = 138;
  localparam int unsigned PK_LATENCY_MSB = 141;
  localparam int unsigned PK_REGWR_BIT   = 142;
  localparam int unsigned PK_W           = 143;

  typedef struct packed {
    logic [31:0] full_instr;
    logic [6:0]  instr_id;
    logic [2:0]  unit_id;
    logic [6:0]  reg_dst;
    logic [3:0]  latency;
    logic        reg_wr;
    logic [6:0]  ra_addr;
    logic [6:0]  rb_addr;
    logic [6:0]  rc_addr;
    logic [2:0]  src_use;
    logic [9:0]  pc;
  } hold_t;

  // Count loaded at fire: max(latency-1, 0); latency 0 behaves like latency 1.
  function automatic logic [3:0] sb_init(input logic [3:0] lat);
    return (lat == 4'd0) ? 4'd0 : lat - 4'd1;
  endfunction

endpackage

// File: rtl/odd_scoreboard_regfile.sv
// Array of per-register in-flight counters: all nonzero entries count down each cycle,
// a single set port overrides the decrement, three combinational read ports.
module odd_scoreboard_regfile
  import odd_issue_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = SB_NREG,
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_addr_i,
  input  logic [CNT_W-1:0]  set_val_i,
  input  logic [REG_AW-1:0] ra_addr_i,
  input  logic [REG_AW-1:0] rb_addr_i,
  input  logic [REG_AW-1:0] rc_addr_i,
  output logic [CNT_W-1:0]  ra_cnt_o,
  output logic [CNT_W-1:0]  rb_cnt_o,
  output logic [CNT_W-1:0]  rc_cnt_o
);

  logic [CNT_W-1:0] sb_q [NREG];
  logic [CNT_W-1:0] sb_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sb_d[i] = (sb_q[i] != '0) ? sb_q[i] - CNT_W'(1) : '0;
    end
    if (set_en_i) begin
      sb_d[set_addr_i] = set_val_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  assign ra_cnt_o = sb_q[ra_addr_i];
  assign rb_cnt_o = sb_q[rb_addr_i];
  assign rc_cnt_o = sb_q[rc_addr_i];

endmodule

// File: rtl/odd_issue_scoreboard.sv
// Odd-pipe issue stage: holds one decoded instruction, blocks it while any used source
// is still in flight, and drives a NOP bubble to the pipe whenever nothing fires.
module odd_issue_scoreboard
  import odd_issue_scoreboard_pkg::*;
#(
  parameter int unsigned NREG    = SB_NREG,
  parameter int unsigned CNT_W   = SB_CNT_W,
  parameter int unsigned STALL_W = SB_STALL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_full_instr,
  input  logic [6:0]         in_instr_id,
  input  logic [2:0]         in_unit_id,
  input  logic [6:0]         in_reg_dst,
  input  logic [3:0]         in_latency,
  input  logic               in_reg_wr,
  input  logic [6:0]         in_ra_addr,
  input  logic [6:0]         in_rb_addr,
  input  logic [6:0]         in_rc_addr,
  input  logic [2:0]         in_src_use,
  input  logic [9:0]         in_pc,
  output logic               issue_valid,
  output logic [31:0]        out_full_instr,
  output logic [6:0]         out_instr_id,
  output logic [2:0]         out_unit_id,
  output logic [6:0]         out_reg_dst,
  output logic [3:0]         out_latency,
  output logic               out_reg_wr,
  output logic [6:0]         out_ra_addr,
  output logic [6:0]         out_rb_addr,
  output logic [6:0]         out_rc_addr,
  output logic [9:0]         out_pc,
  output logic               hazard,
  output logic [STALL_W-1:0] stall_count
);

  hold_t              hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   ra_cnt, rb_cnt, rc_cnt;
  logic               fire, load, sb_set;

  odd_scoreboard_regfile #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (sb_set),
    .set_addr_i (hold_q.reg_dst),
    .set_val_i  (CNT_W'(sb_init(hold_q.latency))),
    .ra_addr_i  (hold_q.ra_addr),
    .rb_addr_i  (hold_q.rb_addr),
    .rc_addr_i  (hold_q.rc_addr),
    .ra_cnt_o   (ra_cnt),
    .rb_cnt_o   (rb_cnt),
    .rc_cnt_o   (rc_cnt)
  );

  always_comb begin
    hazard = hold_valid_q && ((hold_q.src_use[0] && (ra_cnt != '0)) ||
                              (hold_q.src_use[1] && (rb_cnt != '0)) ||
                              (hold_q.src_use[2] && (rc_cnt != '0)));
    fire     = hold_valid_q && !hazard && !flush;
    in_ready = !hold_valid_q || fire || flush;
    // Anything accepted during a flush cycle is squashed along with the held op.
    load     = in_valid && in_ready && !flush;
    sb_set   = fire && hold_q.reg_wr;
  end

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (load) begin
      hold_valid_d      = 1'b1;
      hold_d.full_instr = in_full_instr;
      hold_d.instr_id   = in_instr_id;
      hold_d.unit_id    = in_unit_id;
      hold_d.reg_dst    = in_reg_dst;
      hold_d.latency    = in_latency;
      hold_d.reg_wr     = in_reg_wr;
      hold_d.ra_addr    = in_ra_addr;
      hold_d.rb_addr    = in_rb_addr;
      hold_d.rc_addr    = in_rc_addr;
      hold_d.src_use    = in_src_use;
      hold_d.pc         = in_pc;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard && !flush && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    issue_valid    = fire;
    out_full_instr = hold_q.full_instr;
    out_instr_id   = fire ? hold_q.instr_id : NOP_INSTR_ID;
    out_unit_id    = fire ? hold_q.unit_id : UNIT_NOP;
    out_reg_dst    = hold_q.reg_dst;
    out_latency    = hold_q.latency;
    out_reg_wr     = fire && hold_q.reg_wr;
    out_ra_addr    = hold_q.ra_addr;
    out_rb_addr    = hold_q.rb_addr;
    out_rc_addr    = hold_q.rc_addr;
    out_pc         = hold_q.pc;
    stall_count    = stall_q;
  end

endmodule

// File: tb/tb_odd_issue_scoreboard.sv
// Directed bench for odd_issue_scoreboard: expected issues are queued when offered and
// matched (id, unit, pc, write-enable, cycle) whenever the DUT fires.
module tb_odd_issue_scoreboard;

  localparam logic [2:0] U_PERM = 3'b100;
  localparam logic [2:0] U_LS   = 3'b101;
  localparam logic [2:0] U_BR   = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_full_instr;
  logic [6:0]  in_instr_id;
  logic [2:0]  in_unit_id;
  logic [6:0]  in_reg_dst;
  logic [3:0]  in_latency;
  logic        in_reg_wr;
  logic [6:0]  in_ra_addr, in_rb_addr, in_rc_addr;
  logic [2:0]  in_src_use;
  logic [9:0]  in_pc;
  logic        issue_valid;
  logic [31:0] out_full_instr;
  logic [6:0]  out_instr_id;
  logic [2:0]  out_unit_id;
  logic [6:0]  out_reg_dst;
  logic [3:0]  out_latency;
  logic        out_reg_wr;
  logic [6:0]  out_ra_addr, out_rb_addr, out_rc_addr;
  logic [9:0]  out_pc;
  logic        hazard;
  logic [15:0] stall_count;

  typedef struct {
    logic [6:0] id;
    logic [2:0] unit;
    logic [9:0] pc;
    logic       wr;
    int         cyc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  odd_issue_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_full_instr  (in_full_instr),
    .in_instr_id    (in_instr_id),
    .in_unit_id     (in_unit_id),
    .in_reg_dst     (in_reg_dst),
    .in_latency     (in_latency),
    .in_reg_wr      (in_reg_wr),
    .in_ra_addr     (in_ra_addr),
    .in_rb_addr     (in_rb_addr),
    .in_rc_addr     (in_rc_addr),
    .in_src_use     (in_src_use),
    .in_pc          (in_pc),
    .issue_valid    (issue_valid),
    .out_full_instr (out_full_instr),
    .out_instr_id   (out_instr_id),
    .out_unit_id    (out_unit_id),
    .out_reg_dst    (out_reg_dst),
    .out_latency    (out_latency),
    .out_reg_wr     (out_reg_wr),
    .out_ra_addr    (out_ra_addr),
    .out_rb_addr    (out_rb_addr),
    .out_rc_addr    (out_rc_addr),
    .out_pc         (out_pc),
    .hazard         (hazard),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_full_instr = '0;
    in_instr_id   = '0;
    in_unit_id    = '0;
    in_reg_dst    = '0;
    in_latency    = '0;
    in_reg_wr     = 1'b0;
    in_ra_addr    = '0;
    in_rb_addr    = '0;
    in_rc_addr    = '0;
    in_src_use    = '0;
    in_pc         = '0;
  endtask

  // push: expect this op to issue fire_in cycles after the current cycle.
  task automatic offer(input logic [6:0] id, input logic [2:0] unit, input logic [6:0] dst,
                       input logic [3:0] lat, input logic wr, input logic [6:0] ra,
                       input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] use_bits,
                       input logic [9:0] pc, input bit push, input int fire_in);
    exp_t e;
    in_valid      = 1'b1;
    in_full_instr = {8'hA5, 7'd0, pc, id};
    in_instr_id   = id;
    in_unit_id    = unit;
    in_reg_dst    = dst;
    in_latency    = lat;
    in_reg_wr     = wr;
    in_ra_addr    = ra;
    in_rb_addr    = rb;
    in_rc_addr    = rc;
    in_src_use    = use_bits;
    in_pc         = pc;
    if (push) begin
      e.id   = id;
      e.unit = unit;
      e.pc   = pc;
      e.wr   = wr;
      e.cyc  = cyc + fire_in;
      expq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (issue_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_issue", 32'(expq.size()), 32'd1);
      end else begin
        mon_e = expq.pop_front();
        chk("issue_id", 32'(out_instr_id), 32'(mon_e.id));
        chk("issue_unit", 32'(out_unit_id), 32'(mon_e.unit));
        chk("issue_pc", 32'(out_pc), 32'(mon_e.pc));
        chk("issue_wr", 32'(out_reg_wr), 32'(mon_e.wr));
        chk("issue_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_issue", 32'(issue_valid), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_instr", out_full_instr, 32'd0);
    chk("rst_dst", 32'(out_reg_dst), 32'd0);
    rst = 1'b0;
    tick();
    settle();
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_issue", 32'(issue_valid), 32'd0);
    chk("idle_regwr", 32'(out_reg_wr), 32'd0);

    // Latency-7 load to r5, then an rb=r5 reader stalls six cycles.
    offer(7'd1, U_LS, 7'd5, 4'd7, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 10'h010, 1, 1);
    tick();
    offer(7'd2, U_PERM, 7'd7, 4'd2, 1'b1, 7'd0, 7'd5, 7'd0, 3'b010, 10'h011, 1, 7);
    settle();
    chk("p1_fire", 32'(issue_valid), 32'd1);
    chk("p1_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("p2_hazard", 32'(hazard), 32'd1);
      chk("p2_ready", 32'(in_ready), 32'd0);
      chk("bubble_regwr", 32'(out_reg_wr), 32'd0);
      chk("bubble_unit", 32'(out_unit_id), 32'd0);
      chk("bubble_id", 32'(out_instr_id), 32'd0);
      chk("held_rb", 32'(out_rb_addr), 32'd5);
      tick();
    end
    // Latency-1 permute to r3; rc=r3 reader and an unrelated r4 reader issue back-to-back.
    offer(7'd3, U_PERM, 7'd3, 4'd1, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 10'h020, 1, 1);
    settle();
    chk("p2_clear", 32'(hazard), 32'd0);
    chk("p2_fire", 32'(issue_valid), 32'd1);
    chk("stall_6", 32'(stall_count), 32'd6);
    tick();
    offer(7'd4, U_PERM, 7'd6, 4'd2, 1'b1, 7'd0, 7'd0, 7'd3, 3'b100, 10'h021, 1, 1);
    settle();
    chk("p3_hazard", 32'(hazard), 32'd0);
    chk("p3_ready", 32'(in_ready), 32'd1);
    tick();
    offer(7'd5, U_BR, 7'd0, 4'd1, 1'b0, 7'd4, 7'd0, 7'd0, 3'b001, 10'h022, 1, 1);
    settle();
    chk("p4_hazard", 32'(hazard), 32'd0);
    chk("p4_fire", 32'(issue_valid), 32'd1);
    tick();

    // Reader stalled on r9 gets flushed; the r9 countdown still completes.
    offer(7'd6, U_LS, 7'd9, 4'd6, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 10'h030, 1, 1);
    settle();
    chk("p5_fire", 32'(issue_valid), 32'd1);
    tick();
    offer(7'd7, U_PERM, 7'd1, 4'd1, 1'b1, 7'd9, 7'd0, 7'd0, 3'b001, 10'h031, 0, 0);
    settle();
    chk("p6_fire", 32'(issue_valid), 32'd1);
    tick();
    idle();
    settle();
    chk("p7_hazard", 32'(hazard), 32'd1);
    chk("p7_ra", 32'(out_ra_addr), 32'd9);
    tick();
    flush = 1'b1;
    offer(7'd8, U_PERM, 7'd1, 4'd1, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 10'h032, 0, 0);
    settle();
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_issue", 32'(issue_valid), 32'd0);
    tick();
    flush = 1'b0;
    idle();
    settle();
    chk("post_flush_ready", 32'(in_ready), 32'd1);
    chk("post_flush_hazard", 32'(hazard), 32'd0);
    chk("post_flush_issue", 32'(issue_valid), 32'd0);
    offer(7'd9, U_PERM, 7'd10, 4'd1, 1'b1, 7'd9, 7'd0, 7'd0, 3'b001, 10'h033, 1, 3);
    tick();
    idle();
    settle();
    chk("p9_hazard_a", 32'(hazard), 32'd1);
    tick();
    settle();
    chk("p9_hazard_b", 32'(hazard), 32'd1);
    tick();
    // Store (no reg write) to r2, r2 reader, then a reader with busy rb masked off.
    offer(7'd10, U_LS, 7'd2, 4'd5, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 10'h040, 1, 1);
    settle();
    chk("p9_clear", 32'(hazard), 32'd0);
    chk("p9_fire", 32'(issue_valid), 32'd1);
    chk("stall_9", 32'(stall_count), 32'd9);
    tick();
    offer(7'd11, U_PERM, 7'd12, 4'd5, 1'b1, 7'd2, 7'd0, 7'd0, 3'b001, 10'h041, 1, 1);
    settle();
    chk("store_regwr", 32'(out_reg_wr), 32'd0);
    chk("store_unit", 32'(out_unit_id), 32'(U_LS));
    tick();
    offer(7'd12, U_BR, 7'd0, 4'd1, 1'b0, 7'd0, 7'd12, 7'd0, 3'b001, 10'h042, 1, 1);
    settle();
    chk("store_reader_hazard", 32'(hazard), 32'd0);
    tick();
    // Producer of r5 (count 4), then reset while an r5 reader is held.
    offer(7'd13, U_LS, 7'd5, 4'd5, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 10'h050, 1, 1);
    settle();
    chk("masked_rb_hazard", 32'(hazard), 32'd0);
    chk("masked_rb_fire", 32'(issue_valid), 32'd1);
    tick();
    offer(7'd14, U_PERM, 7'd1, 4'd1, 1'b1, 7'd5, 7'd0, 7'd0, 3'b001, 10'h051, 0, 0);
    tick();
    idle();
    settle();
    chk("p14_hazard", 32'(hazard), 32'd1);
    rst = 1'b1;
    settle();
    chk("midrst_issue", 32'(issue_valid), 32'd0);
    chk("midrst_hazard", 32'(hazard), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_stall", 32'(stall_count), 32'd0);
    chk("midrst_pc", 32'(out_pc), 32'd0);
    chk("midrst_ra", 32'(out_ra_addr), 32'd0);
    tick();
    rst = 1'b0;
    offer(7'd15, U_PERM, 7'd7, 4'd1, 1'b1, 7'd0, 7'd5, 7'd0, 3'b010, 10'h060, 1, 1);
    settle();
    chk("p15_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    settle();
    chk("p15_hazard", 32'(hazard), 32'd0);
    chk("p15_fire", 32'(issue_valid), 32'd1);
    tick();
    tick();
    settle();
    chk("queue_empty", 32'(expq.size()), 32'd0);
    chk("final_stall", 32'(stall_count), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odd_issue_scoreboard.md
Name: odd_issue_scoreboard

Overview:
Issue stage that feeds the odd pipe: permute, load/store and branch units.
- Holds one decoded instruction and checks its source registers against a 128-entry scoreboard of in-flight odd-pipe writes.
- Releases the instruction only when every source value is already visible in the odd pipe's packed forwarding stages.
- Drives the pipe's instruction fields and forces a bubble (no register write) whenever nothing issues.

Parameters:
NREG, 128, number of architectural registers (scoreboard depth; register address width 7).
CNT_W, 4, scoreboard counter width (matches the 4-bit latency field).
STALL_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  branch-taken squash of the held instruction
in_valid  in  1  decode offers an instruction
in_ready  out  1  issue stage accepts this cycle
in_full_instr  in  32  raw instruction word
in_instr_id  in  7  decoded instruction id
in_unit_id  in  3  100 permute, 101 load/store, 110 branch
in_reg_dst  in  7  destination register
in_latency  in  4  pipe stage at which the result is forwardable (1..7)
in_reg_wr  in  1  instruction writes in_reg_dst
in_ra_addr, in_rb_addr, in_rc_addr  in  7 each  source register addresses
in_src_use  in  3  bit0 ra, bit1 rb, bit2 rc used
in_pc  in  10  instruction PC
issue_valid  out  1  held instruction issues this cycle
out_full_instr 32, out_instr_id 7, out_unit_id 3, out_reg_dst 7, out_latency 4, out_reg_wr 1, out_ra_addr 7, out_rb_addr 7, out_rc_addr 7, out_pc 10  out  fields to the odd pipe and register-file read ports
hazard  out  1  held instruction blocked by the scoreboard
stall_count  out  STALL_W  saturating count of hazard cycles

Behaviour:
- Holding register (hold_valid plus fields), loaded on in_valid && in_ready.
  - hazard = hold_valid && OR over used sources of (sb[addr] != 0).
  - fire = issue_valid = hold_valid && !hazard && !flush.
  - in_ready = !hold_valid || fire || flush.
  - Simultaneous fire and load: the new instruction replaces the held one in the same edge, giving throughput of 1 per cycle.
- Output fields come combinationally from the holding register.
  - When fire = 0: out_reg_wr = 0, out_unit_id = 000 and out_instr_id = 0 (NOP bubble), so the pipe produces packed_result with RegWr = 0.
  - out_full_instr, out_pc and the addresses still reflect the held value.
- Scoreboard sb[0:NREG-1], CNT_W bits each. Every cycle, each nonzero entry decrements by 1.
  - On fire with out_reg_wr = 1: sb[dst] <= max(latency-1, 0). This set overrides that entry's decrement.
  - Timing: an instruction firing in cycle C with latency L lets a dependent issue in cycle C+L, when the producer sits in packed_Lstage. For L = 1 the dependent issues back-to-back at C+1.
  - latency 0 is treated as 1. Values above 7 are used as given, with no clamp.
- flush:
  - Clears hold_valid at the edge; the held instruction never fires.
  - Any instruction accepted in the flush cycle is discarded.
  - The scoreboard is not cleared, because in-flight ops still write back.
- Hazard is evaluated only on the held instruction. A held instruction that reads its own destination is unaffected, because the set happens only at its fire.
- stall_count increments on hazard && !flush and saturates at all-ones.
- rst, asynchronous: hold_valid = 0, all sb = 0, stall_count = 0, held fields = 0.
  - Hence after reset: issue_valid = 0, hazard = 0, in_ready = 1, all out_* = 0.
  - Reset mid-stall discards the held instruction.

Decomposition:
- Shared package (opcode_package.vh): unit-id codes (PERM 3'b100, LS 3'b101, BR 3'b110), NOP instr_id, and the packed-stage field offsets (unit [0:2], result [3:130], reg_dst [131:137], latency [138:141], RegWr [142]).
- One natural sub-module: odd_scoreboard_regfile, holding the counter array with set/decrement and three read ports.

Test Plan:
- Reset, then idle: in_ready = 1, issue_valid = 0, out_reg_wr = 0, stall_count = 0.
- Load writing r5 with latency 7 fires in cycle 10; next instruction reads rb = r5 → hazard for cycles 11–16 and fires in cycle 17; stall_count = 6.
- Permute writing r3 with latency 1, followed by an op using rc = r3 → fires the next cycle with no hazard; an unrelated r4 reader also issues back-to-back at 1 per cycle.
- Held instruction stalled on r9 plus flush pulse → issue_valid never asserts for it, hold is empty next cycle, and the sb[r9] countdown continues to 0.
- Producer with in_reg_wr = 0 (store) to r2, then a reader of r2 → no hazard; a src_use bit cleared for a busy rb → no hazard.
- Assert rst while an instruction is held and sb[r5] = 4 → immediately issue_valid = 0 and hazard = 0; after release, a reader of r5 issues on first offer.
